jt12_amp_ramp: RTL



---
 rtl/jt12_amp_pkg.sv | 28 ++
 rtl/jt12_sat.sv | 34 +++
 rtl/jt12_amp_ramp.sv | 135 +++++++++++++
 3 files changed

// File: rtl/jt12_amp_pkg.sv
// Shared types and width helpers for the jt12 output amplifier.
package jt12_amp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Full signed product width: sample times zero-extended gain
    function automatic int unsigned prod_w(input int unsigned wi, input int unsigned gw);
        return wi + gw + 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

    // Saturation limits of a WO-bit signed value, as 64-bit patterns
    function automatic longint sat_hi(input int unsigned wo);
        return (64'sd1 <<< (wo - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_lo(input int unsigned wo);
        return -(64'sd1 <<< (wo - 1));
    endfunction

endpackage

// File: rtl/jt12_sat.sv
// Combinational signed saturator from WIN to WOUT bits with overflow flag.
module jt12_sat
    import jt12_amp_pkg::*;
#(
    parameter int unsigned WIN  = 23,
    parameter int unsigned WOUT = 16
) (
    input  logic signed [WIN-1:0]  din,
    output logic signed [WOUT-1:0] dout,
    output logic                   ovf
);

    localparam logic [WOUT-1:0] LIM_HI = WOUT'(sat_hi(WOUT));
    localparam logic [WOUT-1:0] LIM_LO = WOUT'(sat_lo(WOUT));

    generate
        if (WIN > WOUT) begin : g_narrow
            // In range only when the dropped bits all copy the result sign
            logic [WIN-WOUT:0] top;
            assign top = din[WIN-1:WOUT-1];
            always_comb begin
                ovf  = !((&top) || !(|top));
                dout = din[WOUT-1:0];
                if (ovf) begin
                    dout = din[WIN-1] ? LIM_LO : LIM_HI;
                end
            end
        end else begin : g_wide
            assign dout = WOUT'(din);
            assign ovf  = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/jt12_amp_ramp.sv
// Multichannel gain stage: shared multiplier, saturation, per-frame gain ramp.
module jt12_amp_ramp
    import jt12_amp_pkg::*;
#(
    parameter int unsigned WI   = 14,
    parameter int unsigned WO   = 16,
    parameter int unsigned CH   = 2,
    parameter int unsigned GW   = 8,
    parameter int unsigned FRAC = 4,
    parameter int unsigned STEP = 1,
    parameter int unsigned GRST = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample,
    input  logic [CH*WI-1:0] pre,
    input  logic             gain_ld,
    input  logic [GW-1:0]    gain_tgt,
    input  logic             clip_clr,
    output logic [CH*WO-1:0] post,
    output logic             post_valid,
    output logic             ramping,
    output logic [GW-1:0]    gain_cur,
    output logic [CH-1:0]    clip,
    output logic             overrun
);

    localparam int unsigned PW = prod_w(WI, GW);
    localparam int unsigned KW = cnt_w(CH);
    localparam logic [KW-1:0] K_LAST = KW'(CH - 1);

    state_t              state;
    logic [CH*WI-1:0]    pre_q;
    logic [GW-1:0]       gain_frm;
    logic [GW-1:0]       target;
    logic [KW-1:0]       k;
    logic [CH*WO-1:0]    stage;

    logic signed [WI-1:0] pre_k;
    logic signed [PW-1:0] op_a;
    logic signed [PW-1:0] op_b;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;
    logic signed [WO-1:0] sat_val;
    logic                 sat_ovf;
    logic [CH*WO-1:0]     stage_nxt;
    logic [GW-1:0]        gain_nxt;

    // Shared multiplier path for the channel selected by k
    always_comb begin
        pre_k   = pre_q[k*WI +: WI];
        op_a    = PW'(pre_k);
        op_b    = PW'($signed({1'b0, gain_frm}));
        prod    = op_a * op_b;
        shifted = prod >>> FRAC;
    end

    jt12_sat #(.WIN(PW), .WOUT(WO)) u_sat (
        .din  (shifted),
        .dout (sat_val),
        .ovf  (sat_ovf)
    );

    // Staging with the current channel merged, and the ramp step toward target
    always_comb begin
        stage_nxt              = stage;
        stage_nxt[k*WO +: WO]  = sat_val;
        gain_nxt               = gain_cur;
        if (gain_cur < target) begin
            gain_nxt = ((target - gain_cur) > GW'(STEP)) ? gain_cur + GW'(STEP) : target;
        end else if (gain_cur > target) begin
            gain_nxt = ((gain_cur - target) > GW'(STEP)) ? gain_cur - GW'(STEP) : target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pre_q      <= '0;
            gain_frm   <= GW'(GRST);
            target     <= GW'(GRST);
            gain_cur   <= GW'(GRST);
            k          <= '0;
            stage      <= '0;
            post       <= '0;
            post_valid <= 1'b0;
            ramping    <= 1'b0;
            clip       <= '0;
            overrun    <= 1'b0;
        end else begin
            post_valid <= 1'b0;
            if (gain_ld) begin
                target <= gain_tgt;
            end
            // Clear first so a same-cycle set below takes priority
            if (clip_clr) begin
                clip    <= '0;
                overrun <= 1'b0;
            end
            if (sample && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (sample) begin
                        pre_q    <= pre;
                        gain_frm <= gain_cur;
                        k        <= '0;
                        state    <= MUL;
                    end
                end
                MUL: begin
                    stage <= stage_nxt;
                    if (sat_ovf) begin
                        clip[k] <= 1'b1;
                    end
                    if (k == K_LAST) begin
                        post       <= stage_nxt;
                        post_valid <= 1'b1;
                        state      <= DONE;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DONE: begin
                    gain_cur <= gain_nxt;
                    ramping  <= (gain_nxt != target);
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
